cram_loader: RTL
================

Name: cram_loader

Overview:
- Write-side companion of the CRAM microcode store: loads 84-bit microwords into the CRAM memory's write port and verifies each one by reading it back.
- Console/diagnostic logic (front-end DIAG functions) supplies a start address, then a stream of 21-bit chunks.
- The block assembles each word, writes it, reads it back, compares, and auto-increments the address.
- It owns the CRAM memory address/data/write-enable port while loading; the microsequencer owns it otherwise.

Parameters:
ADDR_W, 12, CRAM address width (CRADR)
WORD_W, 84, microword width, DEC bit numbering [0:83]
CHUNK_W, 21, bits per load chunk; WORD_W/CHUNK_W = 4 chunks per word
RD_LAT, 1, CRAM read latency in cycles (addra to douta), 1..3

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ld_addr_valid  in  1  load start address this cycle
ld_addr  in  ADDR_W  start address
chunk_valid  in  1  chunk offered
chunk_data  in  CHUNK_W  chunk payload
chunk_ready  out  1  chunk accepted when chunk_valid & chunk_ready
clear_err  in  1  clears verify_err/err_addr
mem_addr  out  ADDR_W  CRAM address (current load address)
mem_din  out  WORD_W  assembled word, [0:83]
mem_we  out  1  CRAM write enable
mem_dout  in  WORD_W  CRAM read data
busy  out  1  write/verify in progress
word_done  out  1  one-cycle pulse per verified word
verify_err  out  1  sticky readback mismatch flag
err_addr  out  ADDR_W  address of first mismatch since last clear

Behaviour:
- Reset (async, any state): state=ACCUM; chunk count=0; mem_addr=0; mem_din=0; mem_we=0; busy=0; word_done=0; verify_err=0; err_addr=0; chunk_ready=1 after reset deasserts.
- ACCUM: chunk_ready=1, busy=0.
  - Accepted chunk k (k=0..3) lands in mem_din bits [21k : 21k+20]; chunk 0 fills bits 0:20 and chunk 3 fills bits 63:83. The count then increments.
  - Accepting chunk 3 moves to WRITE on the next cycle.
- ld_addr_valid in ACCUM: mem_addr<=ld_addr, count<=0; partially assembled chunks are discarded (mem_din is not cleared, it is overwritten).
  - If ld_addr_valid and chunk_valid occur in the same cycle, the address load wins and the chunk is not accepted (chunk_ready=0 that cycle).
- ld_addr_valid outside ACCUM is ignored.
- WRITE: exactly one cycle, mem_we=1, busy=1; mem_addr/mem_din stable; chunk_ready=0.
- WAIT: mem_we=0, busy=1; lasts RD_LAT cycles with mem_addr held so mem_dout reflects the written word.
- CHECK: one cycle, busy=1.
  - If mem_dout != mem_din and verify_err=0: verify_err<=1, err_addr<=mem_addr. Later mismatches do not overwrite err_addr.
  - word_done pulses in this cycle on match and on mismatch.
  - mem_addr<=mem_addr+1, wrapping 4095->0; count<=0; next state ACCUM.
- Latency: from acceptance of chunk 3 to word_done = 2+RD_LAT cycles; next chunk is accepted the cycle after CHECK.
- clear_err: synchronous clear of verify_err and err_addr. If it coincides with a CHECK mismatch, the new mismatch wins (flag set, address captured).
- Reset mid-WRITE/WAIT: mem_we drops immediately (async); the partial word is lost; no word_done.
- mem_we is never asserted outside WRITE; no glitch on mem_we from combinational paths (registered output).

Test Plan:
- Reset values: assert reset mid-stream -> all outputs 0 immediately, chunk_ready=1 after release, mem_we never high.
- Single word: ld_addr=0x010, chunks 0x1FFFFF,0x000000,0x155555,0x0AAAAA -> one mem_we pulse at addr 0x010, mem_din = concatenation in that order, word_done 3 cycles later (RD_LAT=1), mem_addr=0x011, verify_err=0.
- Wrap: ld_addr=0xFFE, stream 3 words -> writes at 0xFFE, 0xFFF, 0x000; final mem_addr=0x001; chunk_ready low only during WRITE/WAIT/CHECK.
- Mismatch: model flips bit 40 of readback at addr 0x123 -> verify_err=1, err_addr=0x123. A later mismatch at 0x130 leaves err_addr=0x123. clear_err -> both 0.
- Abort: send 2 chunks, then ld_addr=0x200, then 4 chunks -> one write at 0x200 containing only the 4 new chunks. Simultaneous ld_addr/chunk: the chunk is not accepted.
- Backpressure: chunk_valid held high continuously with RD_LAT=3 -> exactly 4 acceptances per word, 5-cycle gap between words, no chunk lost or duplicated.

Source files
------------

// File: rtl/cram_loader.sv
// CRAM microword loader: assembles 21-bit chunks into 84-bit microwords,
// writes each word into CRAM, reads it back and flags the first mismatch.
// DEC bit i of the microword maps to vector bit WORD_W-1-i, so chunk 0
// (bits 0:20) occupies the most significant slice of mem_din.
module cram_loader #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned WORD_W  = 84,
    parameter int unsigned CHUNK_W = 21,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_addr_valid,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic               chunk_valid,
    input  logic [CHUNK_W-1:0] chunk_data,
    output logic               chunk_ready,
    input  logic               clear_err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_din,
    output logic               mem_we,
    input  logic [WORD_W-1:0]  mem_dout,
    output logic               busy,
    output logic               word_done,
    output logic               verify_err,
    output logic [ADDR_W-1:0]  err_addr
);

    localparam int unsigned NCHUNK = WORD_W / CHUNK_W;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned WAIT_W = 2;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_WRITE,
        ST_WAIT,
        ST_CHECK
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_d;
    logic                rdy_q;
    logic                accept;
    logic                addr_load;
    logic                mismatch;

    // Address load has priority over a chunk offered in the same cycle.
    assign chunk_ready = rdy_q && !ld_addr_valid;
    assign accept      = chunk_valid && chunk_ready;
    assign addr_load   = ld_addr_valid && (state_q == ST_ACCUM);
    assign mismatch    = (mem_dout != mem_din);

    // Next-state logic: chunk counting, write, read-latency wait, verify.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (addr_load) begin
                    cnt_d = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CHECK: begin
                cnt_d   = '0;
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Registered control outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            mem_we    <= (state_d == ST_WRITE);
            busy      <= (state_d != ST_ACCUM);
            word_done <= (state_d == ST_CHECK);
            rdy_q     <= (state_d == ST_ACCUM);
        end
    end

    // Load address and word assembly; address advances after each verify.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            if (addr_load) begin
                mem_addr <= ld_addr;
            end else if (state_q == ST_CHECK) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            for (int unsigned k = 0; k < NCHUNK; k++) begin
                if (accept && (cnt_q == CNT_W'(k))) begin
                    mem_din[WORD_W-1-CHUNK_W*k -: CHUNK_W] <= chunk_data;
                end
            end
        end
    end

    // Sticky readback error; a fresh mismatch beats a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            verify_err <= 1'b0;
            err_addr   <= '0;
        end else if ((state_q == ST_CHECK) && mismatch && (!verify_err || clear_err)) begin
            verify_err <= 1'b1;
            err_addr   <= mem_addr;
        end else if (clear_err) begin
            verify_err <= 1'b0;
            err_addr   <= '0;
        end
    end

endmodule
